// File: rtl/regfile_param_sb.sv
// regfile_param_sb: parametrised multi-read, dual-write register file with per-entry pending scoreboard
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   rd_add / rd_data / rd_valid   NUM_RD combinational read ports, packed port k at [k*W +: W]
//   wr1_*                      write port 1, wins same-address collisions
//   wr2_*                      write port 2
//   rsv_add, rsv_en            reservation port, marks an entry pending until written
//   pending                    registered scoreboard vector
//   wr_coll_cnt                saturating count of same-address dual writes
//   rsv_err                    registered pulse: reserve hit an entry that was already pending
// Build option: define REGFILE_WR_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_param_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 4,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_add,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic [ADDR_W-1:0]          wr1_add,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr2_add,
  input  logic [DATA_W-1:0]          wr2_data,
  input  logic                       wr2_en,
  input  logic [ADDR_W-1:0]          rsv_add,
  input  logic                       rsv_en,
  output logic [DEPTH-1:0]           pending,
  output logic [15:0]                wr_coll_cnt,
  output logic                       rsv_err
);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d, wr_hit;
  logic [15:0]       cnt_q, cnt_d;
  logic              rsv_err_q, rsv_err_d;
  logic              w1, w2, rs, coll;

  function automatic logic is_z(input logic [ADDR_W-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction

  // effective enables after hardwired-zero masking; port 2 yields to port 1 on a shared address
  assign coll = wr1_en && wr2_en && wr1_add == wr2_add && !is_z(wr1_add);
  assign w1   = wr1_en && !is_z(wr1_add);
  assign w2   = wr2_en && !is_z(wr2_add) && !coll;
  assign rs   = rsv_en && !is_z(rsv_add);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    logic hit1, hit2;
    assign hit1         = w1 && wr1_add == IDX;
    assign hit2         = w2 && wr2_add == IDX;
    assign wr_hit[i]    = hit1 || hit2;
    assign regs_d[i]    = hit1 ? wr1_data : hit2 ? wr2_data : regs_q[i];
    // reserve is applied after the write clear, so a same-cycle reserve keeps the entry pending
    assign pending_d[i] = (rs && rsv_add == IDX) || (!wr_hit[i] && pending_q[i]);
  end

  assign rsv_err_d = rs && pending_q[rsv_add] && !wr_hit[rsv_add];
  assign cnt_d     = (coll && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
      cnt_q     <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      rsv_err_q <= rsv_err_d;
    end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              v;
    assign a = rd_add[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_WR_BYPASS_EN
    // forwarding is suppressed while reset is held so reads stay 0 / valid
    logic b1, b2;
    assign b1 = rst_n && w1 && wr1_add == a;
    assign b2 = rst_n && w2 && wr2_add == a;
    assign d  = is_z(a) ? '0 : b1 ? wr1_data : b2 ? wr2_data : regs_q[a];
    assign v  = is_z(a) || b1 || b2 || !pending_q[a];
`else
    assign d  = is_z(a) ? '0 : regs_q[a];
    assign v  = is_z(a) || !pending_q[a];
`endif
    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_valid[k]                 = v;
  end

  assign pending     = pending_q;
  assign wr_coll_cnt = cnt_q;
  assign rsv_err     = rsv_err_q;
endmodule

// File: tb/tb_regfile_param_sb.sv
// tb_regfile_param_sb: scoreboard bench driving a default and a ZERO_REG=1 file with the same stimulus
module tb_regfile_param_sb;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int NR = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_add;
  logic [AW-1:0]    wr1_add, wr2_add, rsv_add;
  logic [DW-1:0]    wr1_data, wr2_data;
  logic             wr1_en, wr2_en, rsv_en;

  logic [NR*DW-1:0] rd_data  [2];
  logic [NR-1:0]    rd_valid [2];
  logic [DP-1:0]    pending  [2];
  logic [15:0]      coll_cnt [2];
  logic             rsv_err  [2];

  regfile_param_sb #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_add(rd_add), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .wr1_add(wr1_add), .wr1_data(wr1_data), .wr1_en(wr1_en),
    .wr2_add(wr2_add), .wr2_data(wr2_data), .wr2_en(wr2_en),
    .rsv_add(rsv_add), .rsv_en(rsv_en),
    .pending(pending[0]), .wr_coll_cnt(coll_cnt[0]), .rsv_err(rsv_err[0]));

  regfile_param_sb #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_add(rd_add), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .wr1_add(wr1_add), .wr1_data(wr1_data), .wr1_en(wr1_en),
    .wr2_add(wr2_add), .wr2_data(wr2_data), .wr2_en(wr2_en),
    .rsv_add(rsv_add), .rsv_en(rsv_en),
    .pending(pending[1]), .wr_coll_cnt(coll_cnt[1]), .rsv_err(rsv_err[1]));

  typedef struct {
    logic [1:0][NR*DW-1:0] d;
    logic [1:0][NR-1:0]    v;
    logic [1:0][DP-1:0]    p;
    logic [1:0][15:0]      c;
    logic [1:0]            e;
  } exp_t;

  exp_t sbq[$];
  int errs = 0;
  int checks = 0;

  // reference state: index 0 = ordinary file, index 1 = register 0 hardwired to zero
  logic [DW-1:0] mreg [2][DP];
  logic [DP-1:0] mpend [2];
  int            mcnt [2];
  logic          merr [2];

  function automatic logic [NR*AW-1:0] rd4(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < DP; i++) mreg[u][i] = '0;
      mpend[u] = '0;
      mcnt[u]  = 0;
      merr[u]  = 1'b0;
    end
  endtask

  // one clock edge of the architectural rules: writes land (port 1 last so it wins), writes clear
  // pending, then a reserve sets it; an error is a reserve on an already-pending, unwritten entry
  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      bit wr [DP];
      bit ok1, ok2, okr;
      for (int i = 0; i < DP; i++) wr[i] = 0;
      ok1 = wr1_en && !(u == 1 && wr1_add == 0);
      ok2 = wr2_en && !(u == 1 && wr2_add == 0);
      okr = rsv_en && !(u == 1 && rsv_add == 0);
      if (ok1 && ok2 && wr1_add == wr2_add && mcnt[u] < 65535) mcnt[u]++;
      if (ok2) begin mreg[u][wr2_add] = wr2_data; wr[wr2_add] = 1; end
      if (ok1) begin mreg[u][wr1_add] = wr1_data; wr[wr1_add] = 1; end
      merr[u] = okr && mpend[u][rsv_add] && !wr[rsv_add];
      for (int i = 0; i < DP; i++) if (wr[i]) mpend[u][i] = 1'b0;
      if (okr) mpend[u][rsv_add] = 1'b1;
    end
  endtask

  task automatic push_exp();
    exp_t x;
    int a;
    logic [DW-1:0] d;
    logic v;
    for (int u = 0; u < 2; u++) begin
      x.p[u] = mpend[u];
      x.c[u] = 16'(mcnt[u]);
      x.e[u] = merr[u];
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_add[k*AW +: AW]);
        d = mreg[u][a];
        v = !mpend[u][a];
`ifdef REGFILE_WR_BYPASS_EN
        if (rst_n && !(u == 1 && a == 0)) begin
          if (wr2_en && int'(wr2_add) == a) begin d = wr2_data; v = 1'b1; end
          if (wr1_en && int'(wr1_add) == a) begin d = wr1_data; v = 1'b1; end
        end
`endif
        x.d[u][k*DW +: DW] = d;
        x.v[u][k]          = v;
      end
    end
    sbq.push_back(x);
  endtask

  task automatic chk(input string name, input int u, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, u, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      for (int u = 0; u < 2; u++) begin
        chk("rd_data", u, rd_data[u], x.d[u]);
        chk("rd_valid", u, (NR*DW)'(rd_valid[u]), (NR*DW)'(x.v[u]));
        chk("pending", u, (NR*DW)'(pending[u]), (NR*DW)'(x.p[u]));
        chk("wr_coll_cnt", u, (NR*DW)'(coll_cnt[u]), (NR*DW)'(x.c[u]));
        chk("rsv_err", u, (NR*DW)'(rsv_err[u]), (NR*DW)'(x.e[u]));
      end
    end

  // called at posedge+1: apply inputs, queue this cycle's expected outputs, then advance the model
  task automatic cycle(input bit e1, input int a1, input logic [DW-1:0] d1,
                       input bit e2, input int a2, input logic [DW-1:0] d2,
                       input bit er, input int ar, input logic [NR*AW-1:0] ra, input bit c);
    wr1_en = e1; wr1_add = AW'(a1); wr1_data = d1;
    wr2_en = e2; wr2_add = AW'(a2); wr2_data = d2;
    rsv_en = er; rsv_add = AW'(ar); rd_add = ra;
    if (c) push_exp();
    @(posedge clk);
    #1;
    if (rst_n) model_step();
  endtask

  task automatic idle(input logic [NR*AW-1:0] ra);
    cycle(0, 0, '0, 0, 0, '0, 0, 0, ra, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr1_en = 0; wr2_en = 0; rsv_en = 0;
    wr1_add = '0; wr2_add = '0; rsv_add = '0;
    wr1_data = '0; wr2_data = '0; rd_add = '0;
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 2, 32'hDEAD_0000, 1, 6, 32'hDEAD_0001, 1, 3, rd4(2, 6, 3, 0), 1);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) idle(rd4(4*c, 4*c+1, 4*c+2, 4*c+3));

    cycle(1, 3, 32'hAAAA_0001, 1, 5, 32'h5555_0002, 0, 0, rd4(3, 5, 0, 1), 1);
    idle(rd4(3, 5, 3, 5));

    cycle(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, rd4(7, 7, 0, 0), 1);
    idle(rd4(7, 0, 0, 0));

    cycle(0, 0, '0, 0, 0, '0, 1, 9, rd4(9, 0, 1, 2), 1);
    idle(rd4(9, 9, 1, 2));
    cycle(1, 9, 32'h1234, 0, 0, '0, 0, 0, rd4(9, 1, 2, 3), 1);
    idle(rd4(9, 1, 2, 3));
    cycle(1, 9, 32'h5678, 0, 0, '0, 1, 9, rd4(9, 1, 2, 3), 1);
    idle(rd4(9, 1, 2, 3));
    cycle(0, 0, '0, 0, 0, '0, 1, 9, rd4(9, 1, 2, 3), 1);
    idle(rd4(9, 1, 2, 3));
    idle(rd4(9, 1, 2, 3));

    cycle(1, 0, 32'hFFFF, 0, 0, '0, 1, 0, rd4(0, 1, 2, 3), 1);
    idle(rd4(0, 0, 1, 2));
    cycle(0, 0, '0, 0, 0, '0, 1, 0, rd4(0, 1, 2, 3), 1);
    cycle(1, 0, 32'h33, 1, 0, 32'h44, 0, 0, rd4(0, 1, 2, 3), 1);
    idle(rd4(0, 0, 0, 0));

    cycle(1, 4, 32'hBEEF, 0, 0, '0, 0, 0, rd4(4, 4, 0, 1), 1);
    idle(rd4(4, 4, 0, 1));
    cycle(0, 0, '0, 1, 4, 32'hCAFE, 0, 0, rd4(4, 1, 2, 3), 1);
    idle(rd4(4, 1, 2, 3));

    for (int n = 0; n < 600; n++)
      cycle($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7),
            rd4($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15)), 1);

    wr1_en = 1; wr1_add = 4; wr1_data = 32'hDEAD_BEEF;
    wr2_en = 1; wr2_add = 4; wr2_data = 32'h0BAD_F00D;
    rsv_en = 1; rsv_add = 6; rd_add = rd4(4, 6, 7, 1);
    #2 rst_n = 1'b0;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    cycle(1, 4, 32'h77, 1, 4, 32'h88, 1, 6, rd4(4, 6, 7, 1), 1);
    rst_n = 1'b1;
    idle(rd4(4, 6, 7, 1));

    for (int n = 0; n < 70000; n++)
      cycle(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, rd4(7, 0, 1, 2), n < 3 || n > 65530);
    idle(rd4(7, 0, 1, 2));
    idle(rd4(7, 0, 1, 2));

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d queued expectations, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
